pu_send_engine: RTL and testbench
=================================

# pu_send_engine

Transmit engine for the processing unit's SEND instruction. It sits directly downstream of the instruction decoder and consumes its `send` strobe together with the register-file values selected by `ra`/`rb` (start address, word count) and the 4-bit immediate (destination port). It streams the addressed data-memory words onto the inter-PU link with a valid/ready handshake, and stalls the PC until the last word is accepted.

## Interface
- `DW`, 16: data word width and address width.
- `PORTS`, 4: number of valid destination ports; legal port ids are 0..PORTS-1.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `send`  in  1  decoder SEND strobe; held high while the PU is stalled on SEND.
- `addr`  in  DW  start data-memory address (ra register value).
- `size`  in  DW  word count (rb register value).
- `port`  in  4  destination port (decoder `iv[3:0]`).
- `stall`  out  1  to PC write-enable gating; high means hold the PC.
- `dm_re`  out  1  data-memory read request.
- `dm_ad`  out  DW  data-memory read address.
- `dm_rd`  in  DW  data-memory read data, valid 1 cycle after `dm_re`.
- `tx_valid`  out  1  link word valid.
- `tx_ready`  in  1  link accepts the word.
- `tx_data`  out  DW  link word.
- `tx_port`  out  4  destination port of the current transfer.
- `tx_last`  out  1  marks the final word.
- `done`  out  1  one-cycle pulse when the transfer completes.
- `err`  out  1  one-cycle pulse when a command with an illegal port is rejected.

## Operation
- States: IDLE, FETCH, LOAD, XMIT, DONE.
- IDLE:
  - If `send` is high, `size != 0` and `port < PORTS`, latch `ptr=addr`, `rem=size`, `tx_port=port`, then go to FETCH.
  - If `send` is high and `port >= PORTS`, pulse `err` next cycle and stay in IDLE. No stall and no transfer.
  - If `send` is high and `size == 0`, ignore the command: no stall, no `done`, no `err`.
- FETCH: `dm_re=1`, `dm_ad=ptr`; go to LOAD.
- LOAD: register `dm_rd` into `tx_data`, set `tx_valid=1`, set `tx_last=(rem==1)`; go to XMIT.
- XMIT: hold `tx_valid`, `tx_data` and `tx_last` stable until `tx_ready`. On handshake, clear `tx_valid`.
  - If `rem==1`, go to DONE.
  - Otherwise `ptr=ptr+1` (wraps mod 2^DW), `rem=rem-1`, and go to FETCH.
- DONE: `done=1` for this cycle, `stall=0`; go to IDLE. `send` is ignored in DONE. The PC advances past SEND at the end of this cycle, so there is no retrigger.
- `send` is ignored in every state except IDLE.
- `stall`:
  - Combinational: high in FETCH, LOAD and XMIT.
  - Also high in IDLE during the cycle a legal, non-zero-size `send` is accepted.
  - Low otherwise.
- Reset values: state IDLE; `tx_valid`, `tx_last`, `dm_re`, `done`, `err` = 0; `tx_data`, `tx_port`, `dm_ad`, `ptr`, `rem` = 0. `stall` is 0 while `send` is low.
- Reset mid-transfer aborts immediately: `tx_valid` drops asynchronously, the remaining words are discarded, and no `done` is issued.

## Timing
- Accept cycle T0 (IDLE, `stall` high), FETCH at T1, LOAD at T2, `tx_valid` high from T3.
- Per-word minimum: 3 cycles (FETCH, LOAD, XMIT with `tx_ready` already high).
- N words with `tx_ready` tied high:
  - Last handshake at T0+3N.
  - DONE at T0+3N+1.
  - `stall` high for cycles T0..T0+3N, i.e. 3N+1 cycles.
- `tx_ready` low stretches XMIT one cycle per low cycle. Outputs are held bit-stable throughout.
- `err` is registered: it pulses in the cycle after the rejected `send`.
- `tx_valid` never asserts without `tx_port` holding the latched port.

## Test plan
- Single word: mem[0x10]=0xBEEF; `send`, addr=0x10, size=1, port=2, `tx_ready`=1.
  - Required: `tx_valid` at T3 with data 0xBEEF, port 2, `tx_last`=1.
  - Required: `done` at T4; `stall` high T0..T3 only.
- Burst with backpressure: mem[0x20..0x22]=1,2,3; size=3.
  - Stimulus: hold `tx_ready` low for 2 cycles on word 2.
  - Required: words 1,2,3 in order; word 2 held stable for 3 cycles; `tx_last` only on word 3.
  - Required: `done` at T0+12.
- Address wrap: addr=0xFFFF, size=2, mem[0xFFFF]=0xA, mem[0x0000]=0xB.
  - Required: `dm_ad` sequence FFFF then 0000; words A then B sent.
- Rejects:
  - port=4 (with PORTS=4): `err` pulse at T1; `stall`, `tx_valid` and `dm_re` never assert.
  - size=0: no output activity at all.
- Reset mid-transfer: assert `rst` while in XMIT of word 2 of 4.
  - Required: `tx_valid` low immediately and `done` never pulses.
  - Required: after release, a new send of size=1 completes normally.
- Held `send`: keep `send` high through DONE.
  - Required: exactly one transfer occurs, and no second acceptance in DONE.

Source files
------------

// File: rtl/pu_send_engine_if.sv
// pu_send_engine_if: SEND command, data-memory read port and inter-PU link bundle.
`timescale 1ns/1ps
interface pu_send_engine_if #(
    parameter int DW = 16
);
    logic          send;
    logic [DW-1:0] addr;
    logic [DW-1:0] size;
    logic [3:0]    port;
    logic          stall;
    logic          dm_re;
    logic [DW-1:0] dm_ad;
    logic [DW-1:0] dm_rd;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic [3:0]    tx_port;
    logic          tx_last;
    logic          done;
    logic          err;
    modport master (
        input  send, addr, size, port, dm_rd, tx_ready,
        output stall, dm_re, dm_ad, tx_valid, tx_data, tx_port, tx_last, done, err
    );
    modport slave (
        output send, addr, size, port, dm_rd, tx_ready,
        input  stall, dm_re, dm_ad, tx_valid, tx_data, tx_port, tx_last, done, err
    );
endinterface

// File: rtl/pu_send_engine.sv
// pu_send_engine: streams data-memory words for a SEND instruction onto the link,
// stalling the PC until the last word is accepted.
`timescale 1ns/1ps
module pu_send_engine #(
    parameter int DW    = 16,
    parameter int PORTS = 4
) (
    input logic             clk,
    input logic             rst,
    pu_send_engine_if.master bus
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, XMIT, DONE} state_t;
    state_t        state_q;
    logic [DW-1:0] ptr_q, rem_q, tx_data_q;
    logic [3:0]    tx_port_q;
    logic          dm_re_q, tx_valid_q, tx_last_q, done_q, err_q;
    logic          legal, accept, reject;
    assign legal  = {1'b0, bus.port} < 5'(PORTS);
    assign accept = state_q == IDLE && bus.send && |bus.size && legal;
    assign reject = state_q == IDLE && bus.send && !legal;
    assign bus.stall    = accept || state_q inside {FETCH, LOAD, XMIT};
    assign bus.dm_re    = dm_re_q;
    // ptr_q always holds the address of the word being fetched
    assign bus.dm_ad    = ptr_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_port  = tx_port_q;
    assign bus.tx_last  = tx_last_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            rem_q      <= '0;
            tx_data_q  <= '0;
            tx_port_q  <= '0;
            dm_re_q    <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_last_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            dm_re_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= reject;
            case (state_q)
                IDLE: if (accept) begin
                    ptr_q     <= bus.addr;
                    rem_q     <= bus.size;
                    tx_port_q <= bus.port;
                    dm_re_q   <= 1'b1;
                    state_q   <= FETCH;
                end
                FETCH: state_q <= LOAD;
                LOAD: begin
                    tx_data_q  <= bus.dm_rd;
                    tx_valid_q <= 1'b1;
                    tx_last_q  <= rem_q == DW'(1);
                    state_q    <= XMIT;
                end
                XMIT: if (bus.tx_ready) begin
                    tx_valid_q <= 1'b0;
                    tx_last_q  <= 1'b0;
                    if (rem_q == DW'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ptr_q   <= ptr_q + DW'(1);
                        rem_q   <= rem_q - DW'(1);
                        dm_re_q <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                // DONE lasts one cycle; send is not sampled there
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pu_send_engine.sv
// tb_pu_send_engine: table-driven SEND transfers plus reset and abort sequences.
`timescale 1ns/1ps
module tb_pu_send_engine;
    typedef struct {
        logic [15:0] addr;
        logic [15:0] size;
        logic [3:0]  port;
        int          low_word;
        int          low_n;
        int          exp_words;
        int          exp_done;
        int          exp_err;
        int          exp_stall;
        logic [15:0] d0;
        logic [15:0] dlast;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] mem [0:65535];
    int checks = 0;
    int errors = 0;
    vec_t vecs [7];

    pu_send_engine_if #(.DW(16)) bus ();
    pu_send_engine #(.DW(16), .PORTS(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.dm_re) bus.dm_rd <= mem[bus.dm_ad];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input string nm);
        int done_n = 0, done_t = -1, err_n = 0, err_t = -1;
        int st_n = 0, st_f = -1, st_l = -1, re_n = 0, word_no, win;
        int low_left = v.low_n;
        logic [15:0] w[$], ad[$];
        logic        l[$];
        logic [3:0]  p[$];
        int          h[$];
        logic        pv = 1'b0, ph = 1'b0, drop;
        logic [15:0] pd = '0, a;
        logic        plast = 1'b0;
        logic [3:0]  pport = '0;
        win = 3 * int'(v.size) + v.low_n + 6;
        @(posedge clk); #1;
        bus.send = 1'b1; bus.addr = v.addr; bus.size = v.size; bus.port = v.port; bus.tx_ready = 1'b1;
        for (int t = 0; t < win; t++) begin
            @(negedge clk);
            if (bus.stall) begin st_n++; if (st_f < 0) st_f = t; st_l = t; end
            if (bus.done) begin done_n++; done_t = t; end
            if (bus.err) begin err_n++; err_t = t; end
            if (bus.dm_re) begin re_n++; ad.push_back(bus.dm_ad); end
            if (bus.tx_valid) begin
                if (pv && !ph) begin
                    chk({nm, ".hold_data"}, 32'(bus.tx_data), 32'(pd));
                    chk({nm, ".hold_last"}, 32'(bus.tx_last), 32'(plast));
                    chk({nm, ".hold_port"}, 32'(bus.tx_port), 32'(pport));
                    h[h.size()-1] = h[h.size()-1] + 1;
                end else begin
                    w.push_back(bus.tx_data); l.push_back(bus.tx_last); p.push_back(bus.tx_port); h.push_back(1);
                end
            end
            ph = bus.tx_valid && bus.tx_ready;
            pv = bus.tx_valid; pd = bus.tx_data; plast = bus.tx_last; pport = bus.tx_port;
            drop = bus.send && !bus.stall;
            @(posedge clk); #1;
            if (drop) bus.send = 1'b0;
            word_no = (pv && !ph) ? w.size() : w.size() + 1;
            if (bus.tx_valid && word_no == v.low_word && low_left > 0) begin
                bus.tx_ready = 1'b0;
                low_left--;
            end else bus.tx_ready = 1'b1;
        end
        chk({nm, ".send_released"}, 32'(bus.send), 32'd0);
        chk({nm, ".words"}, 32'(w.size()), 32'(v.exp_words));
        chk({nm, ".dm_re_count"}, 32'(re_n), 32'(v.exp_words));
        chk({nm, ".done_count"}, 32'(done_n), v.exp_done >= 0 ? 32'd1 : 32'd0);
        chk({nm, ".done_cycle"}, 32'(done_t), 32'(v.exp_done));
        chk({nm, ".err_count"}, 32'(err_n), v.exp_err >= 0 ? 32'd1 : 32'd0);
        chk({nm, ".err_cycle"}, 32'(err_t), 32'(v.exp_err));
        chk({nm, ".stall_cycles"}, 32'(st_n), 32'(v.exp_stall));
        if (v.exp_stall > 0) begin
            chk({nm, ".stall_first"}, 32'(st_f), 32'd0);
            chk({nm, ".stall_last"}, 32'(st_l), 32'(v.exp_stall - 1));
        end
        if (v.exp_words > 0 && w.size() == v.exp_words) begin
            chk({nm, ".first_word"}, 32'(w[0]), 32'(v.d0));
            chk({nm, ".last_word"}, 32'(w[w.size()-1]), 32'(v.dlast));
        end
        for (int i = 0; i < w.size() && i < v.exp_words; i++) begin
            a = v.addr + 16'(i);
            chk($sformatf("%s.data%0d", nm, i), 32'(w[i]), 32'(mem[a]));
            chk($sformatf("%s.last%0d", nm, i), 32'(l[i]), (i == v.exp_words - 1) ? 32'd1 : 32'd0);
            chk($sformatf("%s.port%0d", nm, i), 32'(p[i]), 32'(v.port));
            chk($sformatf("%s.hold%0d", nm, i), 32'(h[i]), (i + 1 == v.low_word) ? 32'(v.low_n + 1) : 32'd1);
        end
        for (int i = 0; i < ad.size() && i < v.exp_words; i++) begin
            a = v.addr + 16'(i);
            chk($sformatf("%s.dm_ad%0d", nm, i), 32'(ad[i]), 32'(a));
        end
    endtask

    initial begin
        int dn, vn;
        bus.send = 1'b0; bus.addr = '0; bus.size = '0; bus.port = '0;
        bus.tx_ready = 1'b1; bus.dm_rd = '0;
        mem[16'h0010] = 16'hBEEF;
        mem[16'h0020] = 16'd1; mem[16'h0021] = 16'd2; mem[16'h0022] = 16'd3;
        mem[16'hFFFF] = 16'h000A; mem[16'h0000] = 16'h000B;
        mem[16'h0030] = 16'h1111; mem[16'h0031] = 16'h2222; mem[16'h0032] = 16'h3333; mem[16'h0033] = 16'h4444;
        mem[16'h0040] = 16'h40A0; mem[16'h0041] = 16'h40A1; mem[16'h0042] = 16'h40A2; mem[16'h0043] = 16'h40A3;
        mem[16'h0050] = 16'h5A5A;
        //          addr      size   port lw ln wd done err stall d0        dlast
        vecs[0] = '{16'h0010, 16'd1, 4'd2, 0, 0, 1, 4,  -1, 4,  16'hBEEF, 16'hBEEF};
        vecs[1] = '{16'h0020, 16'd3, 4'd1, 2, 2, 3, 12, -1, 12, 16'h0001, 16'h0003};
        vecs[2] = '{16'hFFFF, 16'd2, 4'd3, 0, 0, 2, 7,  -1, 7,  16'h000A, 16'h000B};
        vecs[3] = '{16'h0010, 16'd1, 4'd4, 0, 0, 0, -1, 1,  0,  16'h0000, 16'h0000};
        vecs[4] = '{16'h0010, 16'd0, 4'd0, 0, 0, 0, -1, -1, 0,  16'h0000, 16'h0000};
        vecs[5] = '{16'h0020, 16'd5, 4'd15, 0, 0, 0, -1, 1, 0,  16'h0000, 16'h0000};
        vecs[6] = '{16'h0030, 16'd4, 4'd3, 4, 1, 4, 14, -1, 14, 16'h1111, 16'h4444};

        repeat (2) @(posedge clk);
        #1;
        chk("rst.tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst.tx_last", 32'(bus.tx_last), 32'd0);
        chk("rst.dm_re", 32'(bus.dm_re), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.err", 32'(bus.err), 32'd0);
        chk("rst.tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst.tx_port", 32'(bus.tx_port), 32'd0);
        chk("rst.dm_ad", 32'(bus.dm_ad), 32'd0);
        chk("rst.stall", 32'(bus.stall), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("idle.stall", 32'(bus.stall), 32'd0);

        for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("v%0d", i));

        // abort while word 2 of 4 is waiting in XMIT
        @(posedge clk); #1;
        bus.send = 1'b1; bus.addr = 16'h0040; bus.size = 16'd4; bus.port = 4'd1; bus.tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 bus.tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort.pre_valid", 32'(bus.tx_valid), 32'd1);
        chk("abort.pre_data", 32'(bus.tx_data), 32'h40A1);
        chk("abort.pre_last", 32'(bus.tx_last), 32'd0);
        #2 rst = 1'b1; bus.send = 1'b0;
        #1;
        chk("abort.valid_async", 32'(bus.tx_valid), 32'd0);
        chk("abort.stall", 32'(bus.stall), 32'd0);
        @(negedge clk); rst = 1'b0; bus.tx_ready = 1'b1;
        dn = 0; vn = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.done) dn++;
            if (bus.tx_valid) vn++;
        end
        chk("abort.no_done", 32'(dn), 32'd0);
        chk("abort.no_valid", 32'(vn), 32'd0);
        run('{16'h0050, 16'd1, 4'd0, 0, 0, 1, 4, -1, 4, 16'h5A5A, 16'h5A5A}, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
